// File: rtl/grid_arbiter_if.sv
// Grid arbiter bus: clear control, game read-modify-write port and display lookup port.
// master = player/collision logic plus VGA scan side; slave = grid_arbiter.
interface grid_arbiter_if #(
  parameter int CELL_W = 2
);
  logic              clear_req;
  logic              busy;
  logic              clear_done;
  logic              game_req;
  logic              game_we;
  logic [5:0]        game_row;
  logic [6:0]        game_col;
  logic [CELL_W-1:0] game_wdata;
  logic              game_ack;
  logic [CELL_W-1:0] game_rdata;
  logic [5:0]        disp_row;
  logic [6:0]        disp_col;
  logic [CELL_W-1:0] disp_data;

  modport master (
    output clear_req, game_req, game_we, game_row, game_col, game_wdata, disp_row, disp_col,
    input  busy, clear_done, game_ack, game_rdata, disp_data
  );

  modport slave (
    input  clear_req, game_req, game_we, game_row, game_col, game_wdata, disp_row, disp_col,
    output busy, clear_done, game_ack, game_rdata, disp_data
  );
endinterface

// File: rtl/grid_arbiter.sv
// Single-port grid RAM shared by display (even cycles) and game/clear engine (odd cycles).
// Display result 1 cycle after its slot; game requests wait up to 1 cycle, or until a clear finishes.
module grid_arbiter #(
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int MARGIN     = 2,
  parameter int BORDER_VAL = 2,
  parameter int CELL_W     = 2
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  grid_arbiter_if.slave bus
);
  localparam int                CELLS    = COLS * ROWS;
  localparam logic [5:0]        ROW_LIM  = 6'(ROWS);
  localparam logic [6:0]        COL_LIM  = 7'(COLS);
  localparam logic [5:0]        ROW_LAST = 6'(ROWS - 1);
  localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
  localparam logic [5:0]        ROW_MRG  = 6'(MARGIN);
  localparam logic [6:0]        COL_MRG  = 7'(MARGIN);
  localparam logic [5:0]        ROW_BOT  = 6'(ROWS - MARGIN);
  localparam logic [6:0]        COL_RGT  = 7'(COLS - MARGIN);
  localparam logic [CELL_W-1:0] BORDER   = CELL_W'(BORDER_VAL);

  typedef enum logic {S_CLEAR, S_SERVE} state_t;

  state_t            state;
  logic              phase;
  logic [5:0]        cnt_row;
  logic [6:0]        cnt_col;
  logic              busy;
  logic              clear_done;
  logic              game_ack;
  logic [CELL_W-1:0] game_rdata;
  logic [CELL_W-1:0] disp_data;

  logic [CELL_W-1:0] mem [CELLS];

  logic              disp_in;
  logic              game_in;
  logic              clear_border;
  logic              ram_we;
  logic [12:0]       ram_addr;
  logic [CELL_W-1:0] ram_wdata;

  function automatic logic [12:0] cell_addr(input logic [5:0] r, input logic [6:0] c);
    return 13'(r) * 13'(COLS) + 13'(c);
  endfunction

  assign disp_in      = (bus.disp_row < ROW_LIM) && (bus.disp_col < COL_LIM);
  assign game_in      = (bus.game_row < ROW_LIM) && (bus.game_col < COL_LIM);
  assign clear_border = (cnt_row < ROW_MRG) || (cnt_row >= ROW_BOT) ||
                        (cnt_col < COL_MRG) || (cnt_col >= COL_RGT);

  // Out-of-range coordinates are steered to address 0 so the RAM index never leaves the array.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (!phase) begin
      if (disp_in) ram_addr = cell_addr(bus.disp_row, bus.disp_col);
    end else if (state == S_CLEAR) begin
      ram_addr  = cell_addr(cnt_row, cnt_col);
      ram_wdata = clear_border ? BORDER : '0;
      ram_we    = 1'b1;
    end else begin
      if (game_in) ram_addr = cell_addr(bus.game_row, bus.game_col);
      ram_wdata = bus.game_wdata;
      ram_we    = bus.game_req && bus.game_we && game_in;
    end
    if (reset || bus.clear_req) ram_we = 1'b0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_CLEAR;
      phase      <= 1'b0;
      cnt_row    <= '0;
      cnt_col    <= '0;
      busy       <= 1'b1;
      clear_done <= 1'b0;
      game_ack   <= 1'b0;
      game_rdata <= '0;
      disp_data  <= '0;
    end else begin
      phase      <= ~phase;
      clear_done <= 1'b0;
      game_ack   <= 1'b0;
      if (!phase) disp_data <= disp_in ? mem[ram_addr] : BORDER;
      if (bus.clear_req) begin
        state   <= S_CLEAR;
        busy    <= 1'b1;
        cnt_row <= '0;
        cnt_col <= '0;
      end else if (phase) begin
        case (state)
          S_CLEAR: begin
            if (cnt_col == COL_LAST) begin
              cnt_col <= '0;
              if (cnt_row == ROW_LAST) begin
                cnt_row    <= '0;
                state      <= S_SERVE;
                busy       <= 1'b0;
                clear_done <= 1'b1;
              end else begin
                cnt_row <= cnt_row + 6'd1;
              end
            end else begin
              cnt_col <= cnt_col + 7'd1;
            end
          end
          S_SERVE: begin
            if (bus.game_req) begin
              game_ack   <= 1'b1;
              game_rdata <= game_in ? mem[ram_addr] : BORDER;
            end
          end
          default: state <= S_CLEAR;
        endcase
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.clear_done = clear_done;
  assign bus.game_ack   = game_ack;
  assign bus.game_rdata = game_rdata;
  assign bus.disp_data  = disp_data;
endmodule

// File: tb/tb_grid_arbiter.sv
// Directed bench for grid_arbiter: clear pattern, read-before-write, display under load,
// out-of-range accesses, clear restart with a pending request, reset during an access.
module tb_grid_arbiter;
  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic tb_phase = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  grid_arbiter_if #(.CELL_W(2)) bus ();

  grid_arbiter dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Slot phase as the arbiter defines it: 0 out of reset, toggling every cycle.
  always @(posedge clk) tb_phase <= reset ? 1'b0 : ~tb_phase;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic align_phase1();
    while (tb_phase !== 1'b1) tick();
  endtask

  task automatic disp_read(input logic [5:0] r, input logic [6:0] c, output logic [1:0] d);
    bus.disp_row = r;
    bus.disp_col = c;
    tick();
    tick();
    d = bus.disp_data;
  endtask

  task automatic game_access(input logic [5:0] r, input logic [6:0] c, input logic we,
                             input logic [1:0] wd, output int cyc, output logic [1:0] rd);
    bus.game_row   = r;
    bus.game_col   = c;
    bus.game_we    = we;
    bus.game_wdata = wd;
    bus.game_req   = 1'b1;
    cyc = 0;
    rd  = 2'd0;
    do begin
      tick();
      cyc++;
    end while (bus.game_ack !== 1'b1 && cyc < 40);
    if (bus.game_ack === 1'b1) rd = bus.game_rdata;
    else cyc = -1;
    bus.game_req = 1'b0;
    bus.game_we  = 1'b0;
  endtask

  initial begin
    int         dr [6];
    int         dc [6];
    int         dv [6];
    int         cyc;
    int         cnt;
    int         busy_cyc;
    int         done_cnt;
    int         acks;
    logic [1:0] d;

    dr = '{0, 1, 2, 57, 58, 59};
    dc = '{0, 40, 2, 77, 10, 79};
    dv = '{2, 2, 0, 0, 2, 2};

    bus.clear_req  = 1'b0;
    bus.game_req   = 1'b0;
    bus.game_we    = 1'b0;
    bus.game_row   = '0;
    bus.game_col   = '0;
    bus.game_wdata = '0;
    bus.disp_row   = '0;
    bus.disp_col   = '0;

    tick();
    tick();
    check("rst_busy", bus.busy, 1);
    check("rst_clear_done", bus.clear_done, 0);
    check("rst_game_ack", bus.game_ack, 0);
    check("rst_game_rdata", bus.game_rdata, 0);
    check("rst_disp_data", bus.disp_data, 0);

    // Initial clear after reset release
    reset    = 1'b0;
    busy_cyc = 0;
    done_cnt = 0;
    while (bus.busy === 1'b1 && busy_cyc < 12000) begin
      busy_cyc++;
      tick();
      if (bus.clear_done === 1'b1) done_cnt++;
    end
    check("clr_busy_cycles", busy_cyc, 9600);
    check("clr_done_pulses", done_cnt, 1);
    tick();
    check("clr_done_single", bus.clear_done, 0);
    check("clr_busy_low", bus.busy, 0);

    for (int i = 0; i < 6; i++) begin
      disp_read(6'(dr[i]), 7'(dc[i]), d);
      check($sformatf("clr_disp_%0d_%0d", dr[i], dc[i]), d, dv[i]);
    end

    // Read-before-write
    game_access(6'd30, 7'd27, 1'b1, 2'd1, cyc, d);
    check("rbw1_latency_ok", (cyc >= 1 && cyc <= 2) ? 1 : 0, 1);
    check("rbw1_rdata", d, 0);
    game_access(6'd30, 7'd27, 1'b1, 2'd2, cyc, d);
    check("rbw2_ack", (cyc >= 1 && cyc <= 2) ? 1 : 0, 1);
    check("rbw2_rdata", d, 1);
    disp_read(6'd30, 7'd27, d);
    check("rbw_disp", d, 2);

    // Display under continuous game load
    bus.game_req   = 1'b1;
    bus.game_we    = 1'b1;
    bus.game_row   = 6'd40;
    bus.game_col   = 7'd10;
    bus.game_wdata = 2'd1;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.game_ack !== 1'b1 && cnt < 8);
    check("load_first_ack", bus.game_ack, 1);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("load_rdata_%0d", i), bus.game_rdata, (i < 2) ? 0 : 1);
      if (i > 0) check($sformatf("load_disp_%0d", i - 1), bus.disp_data, ((i - 1) % 2 != 0) ? 0 : 2);
      bus.game_col = 7'(10 + ((i + 1) % 2));
      bus.disp_row = (i % 2 != 0) ? 6'd10 : 6'd0;
      bus.disp_col = 7'(5 + i);
      tick();
      check($sformatf("load_gap_%0d", i), bus.game_ack, 0);
      tick();
      check($sformatf("load_ack_%0d", i), bus.game_ack, 1);
    end
    check("load_disp_11", bus.disp_data, 0);
    bus.game_req = 1'b0;
    bus.game_we  = 1'b0;
    tick();

    // Out-of-range accesses
    game_access(6'd60, 7'd5, 1'b1, 2'd1, cyc, d);
    check("oor_row_ack", (cyc > 0) ? 1 : 0, 1);
    check("oor_row_rdata", d, 2);
    game_access(6'd10, 7'd85, 1'b1, 2'd1, cyc, d);
    check("oor_col_ack", (cyc > 0) ? 1 : 0, 1);
    check("oor_col_rdata", d, 2);
    disp_read(6'd11, 7'd5, d);
    check("oor_alias_11_5", d, 0);
    disp_read(6'd0, 7'd5, d);
    check("oor_alias_0_5", d, 2);
    disp_read(6'd20, 7'd80, d);
    check("oor_disp_col80", d, 2);
    disp_read(6'd20, 7'd100, d);
    check("oor_disp_col100", d, 2);
    disp_read(6'd60, 7'd5, d);
    check("oor_disp_row60", d, 2);

    // Clear restart with a request raised during the clear
    align_phase1();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    check("rs_busy", bus.busy, 1);
    done_cnt = 0;
    acks     = 0;
    for (int k = 0; k < 2000; k++) begin
      if (k == 100) begin
        bus.game_row   = 6'd5;
        bus.game_col   = 7'd5;
        bus.game_we    = 1'b1;
        bus.game_wdata = 2'd1;
        bus.game_req   = 1'b1;
      end
      tick();
      if (bus.clear_done === 1'b1) done_cnt++;
      if (bus.game_ack === 1'b1) acks++;
    end
    align_phase1();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    if (bus.clear_done === 1'b1) done_cnt++;
    if (bus.game_ack === 1'b1) acks++;
    check("rs_first_pass_done", done_cnt, 0);
    cnt = 0;
    while (bus.clear_done !== 1'b1 && cnt < 12000) begin
      tick();
      cnt++;
      if (bus.game_ack === 1'b1) acks++;
    end
    check("rs_done_cycles", cnt, 9600);
    check("rs_busy_low", bus.busy, 0);
    check("rs_no_ack_during_clear", acks, 0);
    tick();
    check("rs_pend_ack_early", bus.game_ack, 0);
    tick();
    check("rs_pend_ack", bus.game_ack, 1);
    check("rs_pend_rdata", bus.game_rdata, 0);
    bus.game_req = 1'b0;
    bus.game_we  = 1'b0;
    tick();

    // Reset while an access is pending
    game_access(6'd0, 7'd0, 1'b0, 2'd0, cyc, d);
    check("rm_pre_rdata", d, 2);
    disp_read(6'd0, 7'd0, d);
    check("rm_pre_disp", d, 2);
    align_phase1();
    bus.game_row   = 6'd20;
    bus.game_col   = 7'd20;
    bus.game_we    = 1'b1;
    bus.game_wdata = 2'd1;
    bus.game_req   = 1'b1;
    reset          = 1'b1;
    tick();
    check("rm_ack", bus.game_ack, 0);
    check("rm_rdata", bus.game_rdata, 0);
    check("rm_disp", bus.disp_data, 0);
    check("rm_busy", bus.busy, 1);
    check("rm_clear_done", bus.clear_done, 0);
    reset        = 1'b0;
    bus.game_req = 1'b0;
    bus.game_we  = 1'b0;
    tick();
    tick();
    check("rm_no_late_ack", bus.game_ack, 0);
    check("rm_busy_after", bus.busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/grid_arbiter.md
Name: grid_arbiter

Overview:
- Owns the 80x60 game grid (2-bit cells: 0 empty, 1 player 1 trail, 2 player 2 trail or border).
- Time-multiplexes one single-port grid RAM between three users:
  - the display read path (one lookup per pixel clock);
  - the game-logic port (read-modify-write used for collision checks);
  - an internal clear/border engine.
- Replaces direct multi-driver access to the grid array. It sits between the player/collision logic and the VGA colour mux.

Parameters:
COLS, 80, grid columns
ROWS, 60, grid rows
MARGIN, 2, width in cells of the border ring written during clear
BORDER_VAL, 2, value written to border cells and returned for out-of-range reads
CELL_W, 2, bits per cell

Ports:
CLOCK_50  in  1  system clock; the only clock
reset  in  1  synchronous, active-high; starts a clear
clear_req  in  1  one-cycle pulse; (re)starts a grid clear
busy  out  1  high while the clear engine owns the grid
clear_done  out  1  one-cycle pulse when the last cell has been written
game_req  in  1  game access request; held until game_ack
game_we  in  1  1 = write game_wdata; 0 = read only
game_row  in  6  row coordinate
game_col  in  7  column coordinate
game_wdata  in  CELL_W  value to write
game_ack  out  1  one-cycle pulse; access complete
game_rdata  out  CELL_W  cell contents before the access; valid with game_ack
disp_row  in  6  display lookup row (next_y>>3)
disp_col  in  7  display lookup column (next_x>>3)
disp_data  out  CELL_W  registered display lookup result

Behaviour:
- Clock and reset: one clock (CLOCK_50). reset is synchronous and active-high.
- Slot phase bit:
  - Reset to 0; toggles every cycle.
  - Phase 0 is the display slot. Phase 1 is the game/clear slot.
  - Display bandwidth is fixed at one lookup per 2 cycles, matching the 25 MHz pixel clock. It is never stalled.
- Display slot (phase 0):
  - disp_row/disp_col are sampled.
  - disp_data is updated at the clock edge ending the slot, then held for 2 cycles.
  - Latency is 1 cycle from the sample edge.
  - Out-of-range coordinates (row >= ROWS or col >= COLS) return BORDER_VAL.
- Address computation: row*COLS+col, 13 bits, range 0..4799.
- States:
  - CLEAR
    - One cell is written per phase-1 slot, in row-major order with cnt_row/cnt_col.
    - A cell gets BORDER_VAL if row<MARGIN, row>=ROWS-MARGIN, col<MARGIN or col>=COLS-MARGIN. Otherwise it gets 0.
    - After the write of cell (ROWS-1, COLS-1): pulse clear_done, go to SERVE, busy drops on the same edge.
    - A full clear takes 4800 slots, i.e. 9600 cycles.
  - SERVE
    - In a phase-1 slot with game_req=1, the addressed cell is read into game_rdata.
    - If game_we=1 and the coordinate is in range, game_wdata is written in the same slot (read-before-write).
    - game_ack is pulsed on the edge ending that slot.
    - The requester must drop game_req or present a new request in the cycle after ack. A request still high then is served as a new access in the next phase-1 slot.
    - Requests arriving in phase 0 wait at most 1 cycle.
- Game port boundary conditions:
  - Out-of-range game coordinate: no write, game_rdata=BORDER_VAL, ack still given.
  - game_req during CLEAR: no ack. The request waits and is served in the first phase-1 slot of SERVE.
  - Inputs must stay stable while req is high and unacked.
- Clear restarts:
  - clear_req in SERVE: enter CLEAR with counters zeroed on the next edge. A request that has not yet been acked is not served until the clear completes.
  - clear_req in CLEAR: counters restart from (0,0) and clear_done is not pulsed for the aborted pass.
  - clear_req together with reset: reset wins, with the same effect.
- Reset values:
  - state=CLEAR, phase=0, cnt_row=cnt_col=0.
  - busy=1, clear_done=0, game_ack=0, game_rdata=0, disp_data=0.
  - RAM contents are undefined until the clear completes.
  - reset mid-clear or mid-access aborts it; no ack is issued for the aborted access.

Test Plan:
- Clear contents: assert reset for 1 cycle, release.
  - busy=1 for 9600 cycles.
  - clear_done pulses once, then busy=0.
  - Display reads of (0,0)=2, (1,40)=2, (2,2)=0, (57,77)=0, (58,10)=2, (59,79)=2.
- Read-before-write:
  - Write (30,27)=1: game_ack within 2 cycles of game_req, game_rdata=0.
  - A second write (30,27)=2: game_rdata=1.
  - Display read (30,27): disp_data=2.
- Display under load:
  - Hold game_req continuously with alternating cells.
  - The display sweep still updates disp_data every 2 cycles.
  - Every game access is acked at most once per 2 cycles.
- Out-of-range access:
  - Game write (60,5)=1: ack, game_rdata=2, no cell changed.
  - Display read col=80: disp_data=2.
- Clear restart:
  - Issue clear_req at clear cell 1000: no clear_done for the first pass; done is 9600 cycles after the restart.
  - game_req issued during the clear is acked in the first phase-1 slot after busy falls.
- Reset mid-access: raise reset in the cycle the game request is pending. No ack is issued and outputs return to their reset values.
